buf_owner_arbiter: RTL and testbench

//   Parametrised ownership arbiter for shared buffers and config regions (app_data, UDP RX/TX buffers) between N requesters (ROS2 IP core, CPU, DMA, ...).

---
 rtl/buf_owner_arbiter.sv | 129 ++++++++++++
 tb/tb_buf_owner_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/buf_owner_arbiter.sv
// Exclusive-ownership arbiter: registered one-hot grant, release by pulse, fixed-priority or round-robin.
// Optional hold watchdog enabled by defining ARB_TIMEOUT_EN.
module buf_owner_arbiter #(
   parameter int N_REQ       = 2,
   parameter int RR_MODE     = 0,
   parameter int RESET_OWNER = -1,
   parameter int TIMEOUT_CYC = 1024,
   localparam int IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk_int,
   input  logic             rst_int,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] rel,
   output logic [N_REQ-1:0] grant,
   output logic             grant_any,
   output logic [IDX_W-1:0] owner_idx,
   output logic             proto_err,
   output logic             timeout
);

   typedef enum logic {IDLE, OWNED} state_t;

   function automatic logic [N_REQ-1:0] rst_grant_f();
      logic [N_REQ-1:0] g;
      g = '0;
      for (int i = 0; i < N_REQ; i++)
         if (i == RESET_OWNER) g[i] = 1'b1;
      return g;
   endfunction

   localparam logic [N_REQ-1:0] RST_GRANT = rst_grant_f();
   localparam logic [IDX_W-1:0] RST_IDX   = (RESET_OWNER >= 0) ? IDX_W'(RESET_OWNER) : '0;
   localparam state_t           RST_STATE = (RESET_OWNER >= 0) ? OWNED : IDLE;

   if (N_REQ < 2 || TIMEOUT_CYC < 1) begin : g_param_chk
      $error("buf_owner_arbiter: N_REQ must be >= 2 and TIMEOUT_CYC >= 1");
   end

   state_t           state;
   logic [IDX_W-1:0] rr_last;
   logic             hi_vld, lo_vld, win_vld;
   logic [IDX_W-1:0] hi_idx, lo_idx, win_idx;

   // hi: lowest request above rr_last (RR only); lo: lowest request at/below it.
   // In fixed-priority mode everything lands in lo, i.e. lowest index wins.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            if (RR_MODE != 0 && j > int'(rr_last)) begin
               hi_vld = 1'b1;
               hi_idx = IDX_W'(j);
            end else begin
               lo_vld = 1'b1;
               lo_idx = IDX_W'(j);
            end
         end
      end
      win_vld = hi_vld | lo_vld;
      win_idx = hi_vld ? hi_idx : lo_idx;
   end

`ifdef ARB_TIMEOUT_EN
   logic [31:0] hold_cnt;
`endif

   always_ff @(posedge clk_int) begin
      if (rst_int) begin
         state     <= RST_STATE;
         grant     <= RST_GRANT;
         owner_idx <= RST_IDX;
         grant_any <= (RESET_OWNER >= 0);
         proto_err <= 1'b0;
         rr_last   <= IDX_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
         timeout   <= 1'b0;
         hold_cnt  <= '0;
`endif
      end else begin
         // grant is all-zero in IDLE, so any rel there counts as illegal
         proto_err <= |(rel & ~grant);
`ifdef ARB_TIMEOUT_EN
         timeout   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state     <= OWNED;
                  grant     <= N_REQ'(1) << win_idx;
                  owner_idx <= win_idx;
                  grant_any <= 1'b1;
                  if (RR_MODE != 0) rr_last <= win_idx;
`ifdef ARB_TIMEOUT_EN
                  hold_cnt  <= '0;
`endif
               end
            end
            OWNED: begin
               if (|(rel & grant)) begin
                  state     <= IDLE;
                  grant     <= '0;
                  owner_idx <= '0;
                  grant_any <= 1'b0;
               end
`ifdef ARB_TIMEOUT_EN
               else if (hold_cnt == 32'(TIMEOUT_CYC - 1)) begin
                  state     <= IDLE;
                  grant     <= '0;
                  owner_idx <= '0;
                  grant_any <= 1'b0;
                  timeout   <= 1'b1;
               end else begin
                  hold_cnt  <= hold_cnt + 32'd1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef ARB_TIMEOUT_EN
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_buf_owner_arbiter.sv
// Scoreboard bench: two arbiter instances (2-req fixed-priority reset-owned, 4-req round-robin idle-reset)
// driven in lock-step; a cycle model pushes expected outputs, compared one edge later.
module tb_buf_owner_arbiter;

`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO = 8;

   typedef struct packed {
      logic [3:0] grant;
      logic       any;
      logic [1:0] idx;
      logic       perr;
      logic       tmo;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req_f = '0, rel_f = '0;
   logic [3:0] req_r = '0, rel_r = '0;
   logic [1:0] grant_f;
   logic       any_f, idx_f, perr_f, tmo_f;
   logic [3:0] grant_r;
   logic       any_r, perr_r, tmo_r;
   logic [1:0] idx_r;

   int checks = 0;
   int errors = 0;

   exp_t q_f[$];
   exp_t q_r[$];
   int   seen[$];
   logic prev_any_r = 1'b0;
   int   tmo_cnt = 0;

   // model state, index 0 = u_f, 1 = u_r
   int nr[2]  = '{2, 4};
   int rrm[2] = '{0, 1};
   int ro[2]  = '{1, -1};
   int own[2];
   int rrl[2];
   int cnt[2];

   always #5 clk = ~clk;

   buf_owner_arbiter #(.N_REQ(2), .RR_MODE(0), .RESET_OWNER(1), .TIMEOUT_CYC(TO)) u_f (
      .clk_int(clk), .rst_int(rst), .req(req_f), .rel(rel_f), .grant(grant_f),
      .grant_any(any_f), .owner_idx(idx_f), .proto_err(perr_f), .timeout(tmo_f));

   buf_owner_arbiter #(.N_REQ(4), .RR_MODE(1), .RESET_OWNER(-1), .TIMEOUT_CYC(TO)) u_r (
      .clk_int(clk), .rst_int(rst), .req(req_r), .rel(rel_r), .grant(grant_r),
      .grant_any(any_r), .owner_idx(idx_r), .proto_err(perr_r), .timeout(tmo_r));

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input int d, input bit r, input logic [3:0] rq, input logic [3:0] rl,
                        output exp_t e);
      int w;
      e = '0;
      if (r) begin
         own[d] = ro[d];
         rrl[d] = nr[d] - 1;
         cnt[d] = 0;
      end else begin
         for (int j = 0; j < nr[d]; j++)
            if (rl[j[1:0]] && j != own[d]) e.perr = 1'b1;
         if (own[d] < 0) begin
            w = -1;
            if (rrm[d] != 0) begin
               for (int i = 1; i <= nr[d]; i++) begin
                  int k;
                  k = (rrl[d] + i) % nr[d];
                  if (w < 0 && rq[k[1:0]]) w = k;
               end
            end else begin
               for (int j = 0; j < nr[d]; j++)
                  if (w < 0 && rq[j[1:0]]) w = j;
            end
            if (w >= 0) begin
               own[d] = w;
               cnt[d] = 0;
               if (rrm[d] != 0) rrl[d] = w;
            end
         end else if (rl[own[d][1:0]]) begin
            own[d] = -1;
         end else if (TO_EN && cnt[d] == TO - 1) begin
            own[d] = -1;
            e.tmo  = 1'b1;
         end else begin
            cnt[d]++;
         end
      end
      if (own[d] >= 0) begin
         e.grant = 4'(1 << own[d]);
         e.any   = 1'b1;
         e.idx   = 2'(own[d]);
      end
   endtask

   task automatic step(input bit r, input logic [1:0] rqf, input logic [1:0] rlf,
                       input logic [3:0] rqr, input logic [3:0] rlr);
      exp_t e;
      rst = r; req_f = rqf; rel_f = rlf; req_r = rqr; rel_r = rlr;
      model(0, r, {2'b00, rqf}, {2'b00, rlf}, e);
      q_f.push_back(e);
      model(1, r, rqr, rlr, e);
      q_r.push_back(e);
      @(posedge clk);
      #1;
      e = q_f.pop_front();
      chk("f_grant", int'(grant_f), int'(e.grant));
      chk("f_any",   int'(any_f),   int'(e.any));
      chk("f_idx",   int'(idx_f),   int'(e.idx));
      chk("f_perr",  int'(perr_f),  int'(e.perr));
      chk("f_tmo",   int'(tmo_f),   int'(e.tmo));
      e = q_r.pop_front();
      chk("r_grant", int'(grant_r), int'(e.grant));
      chk("r_any",   int'(any_r),   int'(e.any));
      chk("r_idx",   int'(idx_r),   int'(e.idx));
      chk("r_perr",  int'(perr_r),  int'(e.perr));
      chk("r_tmo",   int'(tmo_r),   int'(e.tmo));
      if (any_r && !prev_any_r) seen.push_back(int'(idx_r));
      prev_any_r = any_r;
      if (tmo_f) tmo_cnt++;
   endtask

   function automatic logic [3:0] own_rel(input int d, input int after);
      if (own[d] >= 0 && cnt[d] == after) return 4'(1 << own[d]);
      return 4'b0;
   endfunction

   initial begin
      int ord[5] = '{0, 1, 2, 3, 0};
      logic [3:0] t;

      // reset: u_f owned by 1, u_r idle
      step(1, 2'b00, 2'b00, 4'h0, 4'h0);
      step(1, 2'b00, 2'b00, 4'h0, 4'h0);
      chk("rst_grant_f", int'(grant_f), 2);
      chk("rst_grant_r", int'(grant_r), 0);
      step(0, 2'b00, 2'b00, 4'h0, 4'h0);
      // illegal rel[0] against owner 1; rel while u_r idle
      step(0, 2'b00, 2'b01, 4'h0, 4'h2);
      chk("perr_f_pulse", int'(perr_f), 1);
      chk("f_hold", int'(grant_f), 2);
      step(0, 2'b00, 2'b00, 4'h0, 4'h0);
      chk("perr_f_single", int'(perr_f), 0);

      // u_r round-robin with all requesting, 3-cycle holds; u_f owner 1 releases, then fixed priority
      seen.delete();
      step(0, 2'b11, 2'b10, 4'hF, 4'h0);
      for (int c = 0; c < 19; c++) begin
         t = own_rel(0, 2);
         step(0, 2'b11, t[1:0], 4'hF, own_rel(1, 2));
      end
      chk("rr_len", seen.size(), 5);
      for (int i = 0; i < 5; i++) chk("rr_order", seen[i], ord[i]);

      // legal + illegal rel in the same cycle on u_f
      for (int c = 0; c < 4 && own[0] < 0; c++) step(0, 2'b11, 2'b00, 4'h0, 4'h0);
      step(0, 2'b00, 2'b11, 4'h0, own_rel(1, cnt[1]));
      chk("f_rel_both", int'(grant_f), 0);
      chk("f_rel_perr", int'(perr_f), 1);
      step(0, 2'b00, 2'b00, 4'h0, 4'h0);

      // u_f holds without rel: watchdog revokes after TO owned cycles when enabled
      tmo_cnt = 0;
      step(0, 2'b01, 2'b00, 4'h0, 4'h0);
      for (int c = 0; c < 12; c++) step(0, 2'b00, 2'b00, 4'h0, 4'h0);
      chk("tmo_pulses", tmo_cnt, TO_EN ? 1 : 0);
      // rel in the final allowed cycle wins over the watchdog
      for (int c = 0; c < 12 && own[0] >= 0; c++) begin
         t = own_rel(0, cnt[0]);
         step(0, 2'b00, t[1:0], 4'h0, 4'h0);
      end
      tmo_cnt = 0;
      step(0, 2'b01, 2'b00, 4'h0, 4'h0);
      for (int c = 0; c < 12; c++) begin
         t = own_rel(0, TO - 1);
         step(0, 2'b00, t[1:0], 4'h0, 4'h0);
      end
      chk("tmo_rel_wins", tmo_cnt, 0);

      // reset mid-ownership of u_r by requester 2
      for (int c = 0; c < 12 && own[1] != 2; c++) step(0, 2'b00, 2'b00, 4'h4, own_rel(1, 0));
      chk("r_owner2", int'(grant_r), 4);
      step(1, 2'b00, 2'b00, 4'h4, 4'h0);
      chk("mid_rst_r", int'(grant_r), 0);
      chk("mid_rst_f", int'(grant_f), 2);
      step(0, 2'b00, 2'b00, 4'hF, 4'h0);
      chk("rr_after_rst", int'(idx_r), 0);

      // random traffic
      for (int c = 0; c < 400; c++) begin
         logic [3:0] a, b;
         a = (($urandom % 4) == 0) ? 4'($urandom) : own_rel(0, cnt[0]) & 4'(($urandom % 3 == 0) ? 15 : 0);
         b = (($urandom % 4) == 0) ? 4'($urandom) : own_rel(1, cnt[1]) & 4'(($urandom % 3 == 0) ? 15 : 0);
         step(($urandom % 64) == 0, 2'($urandom), a[1:0], 4'($urandom), b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
